// File: rtl/osd_dii_typedemux.sv
// DII ingress type demultiplexer: buffers the two header flits of each packet,
// routes register-access packets to the register port and everything else to
// the event port, and counts packets it has to drop.
module osd_dii_typedemux #(
    parameter bit         ENABLE_EVT = 1'b1,
    parameter logic [1:0] REG_CLASS  = 2'b00
) (
    input  logic        clk,
    input  logic        rst,

    input  logic [15:0] in_data,
    input  logic        in_valid,
    input  logic        in_last,
    output logic        in_ready,

    output logic [15:0] reg_data,
    output logic        reg_valid,
    output logic        reg_last,
    input  logic        reg_ready,

    output logic [15:0] evt_data,
    output logic        evt_valid,
    output logic        evt_last,
    input  logic        evt_ready,

    output logic [15:0] drop_cnt
);

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        EMIT0,
        EMIT1,
        STREAM,
        DROP
    } state_t;

    state_t      state;
    logic [15:0] hdr0;
    logic [15:0] hdr1;
    logic        sel;
    logic        last1;

    logic        accept;
    logic        hdr_evt;
    logic        hdr_drop;
    logic        port_valid;
    logic        port_ready;
    logic        port_last;
    logic [15:0] port_data;

    assign accept     = in_valid & in_ready;
    assign hdr_evt    = (in_data[15:14] != REG_CLASS);
    assign hdr_drop   = hdr_evt & ~ENABLE_EVT;
    assign port_ready = sel ? evt_ready : reg_ready;

    // Selected-port view of the datapath and ingress handshake for each state.
    always_comb begin
        in_ready   = 1'b0;
        port_valid = 1'b0;
        port_data  = '0;
        port_last  = 1'b0;
        if (rst) begin
            case (state)
                IDLE, HDR, DROP: in_ready = 1'b1;
                EMIT0: begin
                    port_valid = 1'b1;
                    port_data  = hdr0;
                end
                EMIT1: begin
                    port_valid = 1'b1;
                    port_data  = hdr1;
                    port_last  = last1;
                end
                STREAM: begin
                    port_valid = in_valid;
                    port_data  = in_valid ? in_data : '0;
                    port_last  = in_valid & in_last;
                    in_ready   = port_ready;
                end
                default: in_ready = 1'b0;
            endcase
        end
    end

    // Fan the selected-port view out to exactly one output port.
    always_comb begin
        reg_valid = port_valid & ~sel;
        reg_data  = reg_valid ? port_data : '0;
        reg_last  = reg_valid & port_last;
        evt_valid = port_valid & sel;
        evt_data  = evt_valid ? port_data : '0;
        evt_last  = evt_valid & port_last;
    end

    // Packet sequencing, header capture and saturating drop counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            hdr0     <= '0;
            hdr1     <= '0;
            sel      <= 1'b0;
            last1    <= 1'b0;
            drop_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        hdr0 <= in_data;
                        if (in_last) begin
                            if (drop_cnt != '1) drop_cnt <= drop_cnt + 16'd1;
                        end else begin
                            state <= HDR;
                        end
                    end
                end
                HDR: begin
                    if (accept) begin
                        hdr1  <= in_data;
                        sel   <= hdr_evt;
                        last1 <= in_last;
                        if (hdr_drop) begin
                            if (drop_cnt != '1) drop_cnt <= drop_cnt + 16'd1;
                            state <= in_last ? IDLE : DROP;
                        end else begin
                            state <= EMIT0;
                        end
                    end
                end
                EMIT0: begin
                    if (port_ready) state <= EMIT1;
                end
                EMIT1: begin
                    if (port_ready) state <= last1 ? IDLE : STREAM;
                end
                STREAM: begin
                    if (accept && in_last) state <= IDLE;
                end
                DROP: begin
                    if (accept && in_last) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_osd_dii_typedemux.sv
// Scoreboard bench for osd_dii_typedemux: two instances (event port enabled and
// disabled) share the ingress bus; a packet-level model predicts routed flits
// and drop counts, and a monitor pops and compares every output transfer.
module tb_osd_dii_typedemux;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] in_data;
    logic        in_last;
    logic        drv_valid;
    int          dsel;
    logic        reg_ready;
    logic        evt_ready;
    logic        rnd_rdy;

    logic        in_valid  [2];
    logic        in_ready  [2];
    logic [15:0] reg_data  [2];
    logic        reg_valid [2];
    logic        reg_last  [2];
    logic [15:0] evt_data  [2];
    logic        evt_valid [2];
    logic        evt_last  [2];
    logic [15:0] drop_cnt  [2];

    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    int          acc_cyc;
    int          t0;

    logic [15:0] pkt [$];
    logic [16:0] exp_q [4][$];
    logic [15:0] exp_drop [2];
    int          xcyc [$];

    assign in_valid[0] = drv_valid && (dsel == 0);
    assign in_valid[1] = drv_valid && (dsel == 1);

    always #5 clk = ~clk;

    osd_dii_typedemux u_dut0 (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid[0]), .in_last(in_last), .in_ready(in_ready[0]),
        .reg_data(reg_data[0]), .reg_valid(reg_valid[0]), .reg_last(reg_last[0]), .reg_ready(reg_ready),
        .evt_data(evt_data[0]), .evt_valid(evt_valid[0]), .evt_last(evt_last[0]), .evt_ready(evt_ready),
        .drop_cnt(drop_cnt[0])
    );

    osd_dii_typedemux #(.ENABLE_EVT(1'b0), .REG_CLASS(2'b00)) u_dut1 (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid[1]), .in_last(in_last), .in_ready(in_ready[1]),
        .reg_data(reg_data[1]), .reg_valid(reg_valid[1]), .reg_last(reg_last[1]), .reg_ready(reg_ready),
        .evt_data(evt_data[1]), .evt_valid(evt_valid[1]), .evt_last(evt_last[1]), .evt_ready(evt_ready),
        .drop_cnt(drop_cnt[1])
    );

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (rnd_rdy) begin
            reg_ready = ($urandom_range(0, 3) != 0);
            evt_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: pops expected flits on every output transfer, checks holding under stall.
    initial begin
        logic        hold [4];
        logic [15:0] hd   [4];
        logic        hl   [4];
        logic        v, r, l;
        logic [15:0] d;
        logic [16:0] item;
        int          k;
        for (int j = 0; j < 4; j++) hold[j] = 1'b0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (rst && reg_valid[i] && evt_valid[i]) begin
                    errors++;
                    $display("FAIL both_valid dut%0d got reg=1 evt=1 exp at most one", i);
                end
                for (int p = 0; p < 2; p++) begin
                    k = i * 2 + p;
                    v = p ? evt_valid[i] : reg_valid[i];
                    d = p ? evt_data[i]  : reg_data[i];
                    l = p ? evt_last[i]  : reg_last[i];
                    r = p ? evt_ready    : reg_ready;
                    if (!rst) begin
                        hold[k] = 1'b0;
                    end else begin
                        if (!v && (d != 16'h0 || l)) begin
                            errors++;
                            $display("FAIL idle_zero dut%0d port%0d got %h/%b exp 0000/0", i, p, d, l);
                        end
                        if (hold[k]) begin
                            checks++;
                            if (!v || d != hd[k] || l != hl[k]) begin
                                errors++;
                                $display("FAIL hold dut%0d port%0d got v=%b %h/%b exp v=1 %h/%b",
                                         i, p, v, d, l, hd[k], hl[k]);
                            end
                        end
                        if (v && r) begin
                            if (i == 0 && p == 0) xcyc.push_back(cyc);
                            checks++;
                            if (exp_q[k].size() == 0) begin
                                errors++;
                                $display("FAIL unexpected dut%0d port%0d got %h/%b exp no transfer", i, p, d, l);
                            end else begin
                                item = exp_q[k].pop_front();
                                if ({l, d} != item) begin
                                    errors++;
                                    $display("FAIL flit dut%0d port%0d got %h/%b exp %h/%b",
                                             i, p, d, l, item[15:0], item[16]);
                                end
                            end
                        end
                        hold[k] = v && !r;
                        hd[k]   = d;
                        hl[k]   = l;
                    end
                end
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog got no finish exp finish before 5ms");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s got %h exp %h", name, act, expv);
        end
    endtask

    task automatic model_drop(input int d);
        if (exp_drop[d] != 16'hFFFF) exp_drop[d] = exp_drop[d] + 16'd1;
    endtask

    // Packet-level reference: runts and unroutable events drop, others forward whole.
    task automatic model_pkt();
        int is_evt;
        if (pkt.size() < 2) begin
            model_drop(dsel);
        end else begin
            is_evt = (pkt[1][15:14] != 2'b00) ? 1 : 0;
            if (is_evt == 1 && dsel == 1) begin
                model_drop(dsel);
            end else begin
                for (int j = 0; j < pkt.size(); j++)
                    exp_q[dsel * 2 + is_evt].push_back({(j == pkt.size() - 1), pkt[j]});
            end
        end
    endtask

    task automatic flush_model();
        for (int j = 0; j < 4; j++) exp_q[j].delete();
        exp_drop[0] = 16'h0;
        exp_drop[1] = 16'h0;
    endtask

    // Called at posedge+1; returns at posedge+1 after the flit has been accepted.
    task automatic send_flit(input logic [15:0] dat, input logic lst);
        int n = 0;
        in_data   = dat;
        in_last   = lst;
        drv_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready[dsel]) begin
                acc_cyc = cyc;
                break;
            end
            n++;
            if (n > 300) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout dut%0d got no in_ready exp accept within 300 cycles", dsel);
                break;
            end
        end
        @(posedge clk);
        #1;
        drv_valid = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
    endtask

    task automatic send_pkt(input bit gaps);
        model_pkt();
        for (int j = 0; j < pkt.size(); j++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
            end
            send_flit(pkt[j], (j == pkt.size() - 1));
            if (j == 0) t0 = acc_cyc;
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size()) != 0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout got %0d flits pending exp 0",
                     exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size());
        end
        repeat (2) @(negedge clk);
        chk("drop_cnt0", drop_cnt[0], exp_drop[0]);
        chk("drop_cnt1", drop_cnt[1], exp_drop[1]);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        int len;
        rst       = 1'b0;
        drv_valid = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        dsel      = 0;
        reg_ready = 1'b1;
        evt_ready = 1'b1;
        rnd_rdy   = 1'b0;
        flush_model();

        // Reset state
        #3;
        chk("rst_in_ready0", in_ready[0], 0);
        chk("rst_reg_valid0", reg_valid[0], 0);
        chk("rst_evt_valid0", evt_valid[0], 0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready0", in_ready[0], 1);
        chk("post_rst_drop0", drop_cnt[0], 0);
        @(posedge clk);
        #1;

        // Read-reg packet latency
        xcyc.delete();
        dsel = 0;
        pkt = '{16'h0005, 16'h2003, 16'h0000};
        send_pkt(1'b0);
        drain();
        chk("lat_count", xcyc.size(), 3);
        if (xcyc.size() == 3) begin
            for (int j = 0; j < 3; j++) chk("lat_cycle", xcyc[j], t0 + 2 + j);
        end

        // Event packet with stalled evt_ready during EMIT0
        evt_ready = 1'b0;
        pkt = '{16'h0005, 16'h8003, 16'h1234, 16'hABCD};
        fork
            send_pkt(1'b0);
            begin
                n = 0;
                do begin
                    @(negedge clk);
                    n++;
                end while (!evt_valid[0] && n < 50);
                chk("stall_seen", evt_valid[0], 1);
                for (int j = 0; j < 3; j++) begin
                    chk("stall_data", evt_data[0], 16'h0005);
                    chk("stall_in_ready", in_ready[0], 0);
                    @(negedge clk);
                end
                @(posedge clk);
                #1;
                evt_ready = 1'b1;
            end
        join
        drain();

        // Event packets dropped when the event port is disabled
        dsel = 1;
        pkt = '{16'h0005, 16'h4003, 16'h1111, 16'h2222};
        send_pkt(1'b0);
        drain();
        chk("noevt_drop", drop_cnt[1], 1);
        pkt = '{16'h0005, 16'h2003, 16'h0000};
        send_pkt(1'b0);
        drain();

        // Runt then 2-flit packet
        dsel = 0;
        pkt = '{16'h0005};
        send_pkt(1'b0);
        pkt = '{16'h0005, 16'h2003};
        send_pkt(1'b0);
        drain();
        chk("runt_drop", drop_cnt[0], 1);

        // Randomized traffic with random backpressure
        rnd_rdy = 1'b1;
        for (int p = 0; p < 150; p++) begin
            dsel = $urandom_range(0, 1);
            len  = $urandom_range(1, 6);
            pkt.delete();
            pkt.push_back({6'h0, 10'($urandom)});
            if (len > 1) pkt.push_back({4'($urandom_range(0, 15)), 2'b00, 10'($urandom)});
            for (int j = 2; j < len; j++) pkt.push_back(16'($urandom));
            send_pkt(1'b1);
        end
        drain();
        rnd_rdy   = 1'b0;
        reg_ready = 1'b1;
        evt_ready = 1'b1;

        // Reset asserted mid-stream of an event packet
        dsel = 0;
        pkt = '{16'h0005, 16'h8003, 16'h0001, 16'h0002, 16'h0003, 16'h0004};
        model_pkt();
        for (int j = 0; j < 3; j++) send_flit(pkt[j], 1'b0);
        in_data   = 16'h0002;
        in_last   = 1'b0;
        drv_valid = 1'b1;
        #2;
        chk("pre_rst_evt_valid", evt_valid[0], 1);
        rst = 1'b0;
        #1;
        chk("mid_rst_evt_valid", evt_valid[0], 0);
        chk("mid_rst_evt_data", evt_data[0], 0);
        chk("mid_rst_reg_valid", reg_valid[0], 0);
        chk("mid_rst_in_ready", in_ready[0], 0);
        chk("mid_rst_drop0", drop_cnt[0], 0);
        drv_valid = 1'b0;
        in_data   = '0;
        flush_model();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        pkt = '{16'h0007, 16'h3001, 16'h00AA};
        send_pkt(1'b0);
        drain();

        // Drop counter saturation
        dsel = 0;
        pkt = '{16'h0005};
        while (exp_drop[0] != 16'hFFFF) send_pkt(1'b0);
        @(negedge clk);
        chk("sat_reach", drop_cnt[0], 16'hFFFF);
        @(posedge clk);
        #1;
        send_pkt(1'b0);
        @(negedge clk);
        chk("sat_hold", drop_cnt[0], 16'hFFFF);
        @(posedge clk);
        #1;
        pkt = '{16'h0005, 16'h2003, 16'h0000};
        send_pkt(1'b0);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/osd_dii_typedemux.md
Name: osd_dii_typedemux

Overview:
- Ingress stage in front of a debug module's status/control interface.
- Accepts every DII packet addressed to this module, buffers the two header flits, and classifies the packet by its type field.
- Register-access packets go to the register port, which feeds the status/control interface. All other packets go to the event port, which feeds module-specific logic.
- Malformed or unroutable packets are dropped and counted.

Parameters:
- ENABLE_EVT, 1: 1 = non-register packets go to the event port; 0 = they are dropped and counted.
- REG_CLASS, 2'b00: value of type bits [15:14] that marks a register-access packet (read-reg 4'b0010, write-reg 4'b0011, ...).

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous, active-low reset.
- in_data  input  16  ingress flit.
- in_valid  input  1  ingress flit valid.
- in_last  input  1  ingress last flit of packet.
- in_ready  output  1  ingress flit accepted when in_valid & in_ready.
- reg_data  output  16  register-port flit.
- reg_valid  output  1  register-port valid.
- reg_last  output  1  register-port last.
- reg_ready  input  1  register-port ready.
- evt_data  output  16  event-port flit.
- evt_valid  output  1  event-port valid.
- evt_last  output  1  event-port last.
- evt_ready  input  1  event-port ready.
- drop_cnt  output  16  saturating count of dropped packets.

Behaviour:
- Packet format:
  - flit0 = dest[9:0].
  - flit1 = {type[15:12], 2'b0, src[9:0]}.
  - flit2.. = payload.
- Registered state:
  - state; hdr0[15:0]; hdr1[15:0]; sel (0 = reg, 1 = evt); drop_cnt.
  - All are async-cleared when rst is low: state = IDLE, hdr0 = hdr1 = 0, sel = 0, drop_cnt = 0.
- While rst is low, in_ready = 0 and all *_valid = 0; *_data and *_last = 0 when the port is not valid.
- IDLE:
  - in_ready = 1.
  - On accept: hdr0 <= in_data.
  - If in_last, this is a 1-flit runt: drop it (drop_cnt++) and stay in IDLE. Otherwise go to HDR.
- HDR:
  - in_ready = 1.
  - On accept: hdr1 <= in_data; sel <= (in_data[15:14] != REG_CLASS).
  - If sel would be 1 and ENABLE_EVT = 0, drop the packet (drop_cnt++): go to IDLE if in_last, else DROP. Otherwise go to EMIT0.
  - The in_last of flit1 is stored so that a 2-flit packet is forwarded complete.
- EMIT0:
  - in_ready = 0.
  - Selected port: valid = 1, data = hdr0, last = 0.
  - On that port's ready, go to EMIT1.
- EMIT1:
  - in_ready = 0.
  - Selected port: valid = 1, data = hdr1, last = stored flit1 last.
  - On ready: if stored last, go to IDLE; else STREAM.
- STREAM:
  - Combinational pass-through to the selected port: valid = in_valid, data = in_data, last = in_last, in_ready = selected port's ready.
  - On a transfer with in_last, go to IDLE.
  - The unselected port stays valid = 0.
- DROP:
  - in_ready = 1; discard flits; go to IDLE on accepted in_last.
- Ports never both valid in the same cycle. Once valid is raised, data and last must hold until ready; EMIT states guarantee this, and STREAM inherits it from the upstream.
- Latency:
  - flit0 accepted at cycle t, flit1 at t+1.
  - hdr0 presented from t+2, hdr1 from t+3 at the earliest.
  - Payload then streams at 1 flit/cycle with zero added latency.
- Back-to-back: IDLE is entered in the same cycle the last flit transfers, so the next packet's flit0 can be accepted the following cycle.
- drop_cnt:
  - Increments once per dropped packet, at the decision cycle (IDLE runt, or HDR drop).
  - Saturates at 16'hFFFF with no wrap.
- Reset asserted mid-packet: all state is cleared asynchronously. On release, the block is in IDLE and treats the next accepted flit as flit0; partial packets are not recovered.
- Output backpressure during EMIT or STREAM stalls ingress only; no flit is duplicated or lost.

Test Plan:
- Read-reg packet {0x0005, 0x2003, 0x0000 last}, both readies = 1 -> reg port emits 0x0005, 0x2003, 0x0000 (last on third) on cycles t+2, t+3, t+4; evt_valid stays 0; drop_cnt = 0.
- Event packet {0x0005, 0x8003, 0x1234, 0xABCD last} with evt_ready low for 3 cycles during EMIT0 -> evt_data holds 0x0005 stable while stalled; then all 4 flits emitted in order, last on 0xABCD; in_ready = 0 during the stall.
- ENABLE_EVT = 0 with packet {0x0005, 0x4003, 0x1111, 0x2222 last} -> no output valid; all flits accepted; drop_cnt = 1; a following read-reg packet is routed normally.
- Runt 1-flit packet {0x0005 last}, then 2-flit packet {0x0005, 0x2003 last} -> drop_cnt = 1; reg port emits 2 flits with last on 0x2003.
- Assert rst mid-STREAM of an event packet -> outputs go invalid immediately and drop_cnt = 0; after release a read-reg packet is routed correctly. Also preload drop_cnt to 0xFFFF via drops and check it holds at 0xFFFF after a further drop.
